// File: rtl/commit_ctrl_n_if.sv
`default_nettype none
// ============================================================================
// Module   : commit_ctrl_n_if
// Purpose  : WB-lane, CSR and pipeline-control bundle for commit_ctrl_n.
// Revision : 1.0
// ============================================================================
interface commit_ctrl_n_if #(
    parameter int COMMIT_WIDTH   = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int FTQ_ID_WIDTH   = 3,
    parameter int EXCP_NUM_WIDTH = 16,
    parameter int STAGE_NUM      = 7
);
    logic [COMMIT_WIDTH-1:0]                lane_valid_i;
    logic [COMMIT_WIDTH*ADDR_WIDTH-1:0]     lane_pc_i;
    logic [COMMIT_WIDTH-1:0]                lane_excp_i;
    logic [COMMIT_WIDTH*EXCP_NUM_WIDTH-1:0] lane_excp_num_i;
    logic [COMMIT_WIDTH*2-1:0]              lane_kind_i;
    logic [COMMIT_WIDTH*FTQ_ID_WIDTH-1:0]   lane_ftq_id_i;
    logic [COMMIT_WIDTH-1:0]                lane_is_last_i;
    logic [3*COMMIT_WIDTH-1:0]              stage_ready_i;
    logic                                   int_pending_i;
    logic [ADDR_WIDTH-1:0]                  csr_eentry_i;
    logic [ADDR_WIDTH-1:0]                  csr_tlbrentry_i;
    logic [ADDR_WIDTH-1:0]                  csr_era_i;

    logic [COMMIT_WIDTH-1:0]                commit_mask_o;
    logic [COMMIT_WIDTH-1:0]                commit_block_o;
    logic [FTQ_ID_WIDTH-1:0]                flush_ftq_id_o;
    logic [STAGE_NUM-1:0]                   flush_o;
    logic [STAGE_NUM-1:0]                   advance_o;
    logic                                   redirect_valid_o;
    logic [ADDR_WIDTH-1:0]                  redirect_pc_o;
    logic                                   excp_valid_o;
    logic [EXCP_NUM_WIDTH-1:0]              excp_num_o;
    logic [ADDR_WIDTH-1:0]                  excp_era_o;
    logic                                   ertn_o;
    logic                                   in_idle_o;
    logic [31:0]                            retired_cnt_o;

    modport master (
        output lane_valid_i, lane_pc_i, lane_excp_i, lane_excp_num_i, lane_kind_i,
               lane_ftq_id_i, lane_is_last_i, stage_ready_i, int_pending_i,
               csr_eentry_i, csr_tlbrentry_i, csr_era_i,
        input  commit_mask_o, commit_block_o, flush_ftq_id_o, flush_o, advance_o,
               redirect_valid_o, redirect_pc_o, excp_valid_o, excp_num_o,
               excp_era_o, ertn_o, in_idle_o, retired_cnt_o
    );

    modport slave (
        input  lane_valid_i, lane_pc_i, lane_excp_i, lane_excp_num_i, lane_kind_i,
               lane_ftq_id_i, lane_is_last_i, stage_ready_i, int_pending_i,
               csr_eentry_i, csr_tlbrentry_i, csr_era_i,
        output commit_mask_o, commit_block_o, flush_ftq_id_o, flush_o, advance_o,
               redirect_valid_o, redirect_pc_o, excp_valid_o, excp_num_o,
               excp_era_o, ertn_o, in_idle_o, retired_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/commit_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : commit_ctrl_n
// Purpose  : WB-stage commit controller: break-lane select, redirect, flush,
//            advance, idle-wait FSM with interrupt wake-up, retired counter.
// Revision : 1.0
// ============================================================================
module commit_ctrl_n #(
    parameter int COMMIT_WIDTH   = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int FTQ_ID_WIDTH   = 3,
    parameter int EXCP_NUM_WIDTH = 16,
    parameter int STAGE_NUM      = 7
) (
    input  logic           clk,
    input  logic           rst,
    commit_ctrl_n_if.slave bus
);
    localparam logic [1:0] c_KIND_ERTN    = 2'd1;
    localparam logic [1:0] c_KIND_IDLE    = 2'd2;
    localparam logic [1:0] c_KIND_REFETCH = 2'd3;

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_IDLE = 2'd1, ST_WAKE = 2'd2} state_e;

    state_e                    state_q, state_d;
    logic [31:0]               retired_q, retired_d;
    logic                      adv_delay_q;
    logic [ADDR_WIDTH-1:0]     idle_pc_q, idle_pc_d;

    logic                      w_seen;
    logic                      w_is_brk;
    logic [ADDR_WIDTH-1:0]     w_brk_pc;
    logic                      w_brk_excp;
    logic [EXCP_NUM_WIDTH-1:0] w_brk_num;
    logic [1:0]                w_brk_kind;
    logic [FTQ_ID_WIDTH-1:0]   w_brk_ftq;
    logic [COMMIT_WIDTH-1:0]   w_mask, w_block;
    logic [31:0]               w_pop;
    logic                      w_advance;
    logic [STAGE_NUM-1:0]      w_adv_vec, w_flush;
    logic                      w_rv, w_xv, w_ertn;
    logic [ADDR_WIDTH-1:0]     w_rpc, w_era;
    logic [EXCP_NUM_WIDTH-1:0] w_num;
    logic [FTQ_ID_WIDTH-1:0]   w_ftq;

    assign w_advance = &bus.stage_ready_i;

    // Oldest-first scan; lanes at or after the break lane never commit past it.
    always_comb begin
        w_seen     = 1'b0;
        w_is_brk   = 1'b0;
        w_brk_pc   = '0;
        w_brk_excp = 1'b0;
        w_brk_num  = '0;
        w_brk_kind = '0;
        w_brk_ftq  = '0;
        w_mask     = '0;
        w_block    = '0;
        w_pop      = '0;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                w_is_brk = !w_seen && bus.lane_valid_i[i] &&
                           (bus.lane_excp_i[i] || (bus.lane_kind_i[i*2 +: 2] != 2'd0));
                if (!w_seen) begin
                    w_mask[i]  = bus.lane_valid_i[i] & ~(w_is_brk & bus.lane_excp_i[i]);
                    w_block[i] = (w_mask[i] & bus.lane_is_last_i[i]) | w_is_brk;
                end
                if (w_is_brk) begin
                    w_brk_pc   = bus.lane_pc_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    w_brk_excp = bus.lane_excp_i[i];
                    w_brk_num  = bus.lane_excp_num_i[i*EXCP_NUM_WIDTH +: EXCP_NUM_WIDTH];
                    w_brk_kind = bus.lane_kind_i[i*2 +: 2];
                    w_brk_ftq  = bus.lane_ftq_id_i[i*FTQ_ID_WIDTH +: FTQ_ID_WIDTH];
                end
                w_seen = w_seen | w_is_brk;
                w_pop  = w_pop + {31'd0, w_mask[i]};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idle_pc_d = idle_pc_q;
        w_rv      = 1'b0;
        w_rpc     = '0;
        w_xv      = 1'b0;
        w_num     = '0;
        w_era     = '0;
        w_ertn    = 1'b0;
        w_ftq     = '0;
        w_adv_vec = {STAGE_NUM{w_advance}};
        case (state_q)
            ST_RUN: begin
                if (w_seen) begin
                    w_rv  = 1'b1;
                    w_ftq = w_brk_ftq;
                    if (w_brk_excp) begin
                        w_xv  = 1'b1;
                        w_num = w_brk_num;
                        w_era = w_brk_pc;
                        w_rpc = (w_brk_num[2] | w_brk_num[11]) ? bus.csr_tlbrentry_i
                                                               : bus.csr_eentry_i;
                    end else if (w_brk_kind == c_KIND_ERTN) begin
                        w_ertn = 1'b1;
                        w_rpc  = bus.csr_era_i;
                    end else if (w_brk_kind == c_KIND_IDLE) begin
                        w_rpc     = w_brk_pc + ADDR_WIDTH'(4);
                        idle_pc_d = w_brk_pc + ADDR_WIDTH'(4);
                        state_d   = ST_IDLE;
                    end else if (w_brk_kind == c_KIND_REFETCH) begin
                        w_rpc = w_brk_pc + ADDR_WIDTH'(4);
                    end
                end
            end
            ST_IDLE: begin
                w_adv_vec[STAGE_NUM-1] = 1'b0;
                if (bus.int_pending_i) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                w_rv    = 1'b1;
                w_rpc   = bus.csr_eentry_i;
                w_xv    = 1'b1;
                w_num   = EXCP_NUM_WIDTH'(1);
                w_era   = idle_pc_q;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        w_flush    = {STAGE_NUM{w_rv}};
        w_flush[0] = w_flush[0] | (adv_delay_q & ~w_advance);
        retired_d  = w_advance ? (retired_q + w_pop) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            retired_q   <= '0;
            adv_delay_q <= 1'b1;
            idle_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            retired_q   <= retired_d;
            adv_delay_q <= w_advance;
            idle_pc_q   <= idle_pc_d;
        end
    end

    // Reset forces every output quiet except advance, which is held open.
    assign bus.commit_mask_o    = rst ? '0 : w_mask;
    assign bus.commit_block_o   = rst ? '0 : w_block;
    assign bus.flush_ftq_id_o   = rst ? '0 : w_ftq;
    assign bus.flush_o          = rst ? '0 : w_flush;
    assign bus.advance_o        = rst ? '1 : w_adv_vec;
    assign bus.redirect_valid_o = rst ? 1'b0 : w_rv;
    assign bus.redirect_pc_o    = rst ? '0 : w_rpc;
    assign bus.excp_valid_o     = rst ? 1'b0 : w_xv;
    assign bus.excp_num_o       = rst ? '0 : w_num;
    assign bus.excp_era_o       = rst ? '0 : w_era;
    assign bus.ertn_o           = rst ? 1'b0 : w_ertn;
    assign bus.in_idle_o        = rst ? 1'b0 : (state_q == ST_IDLE);
    assign bus.retired_cnt_o    = rst ? '0 : retired_q;
endmodule
`default_nettype wire
